// File: rtl/mode_counter.sv
// Up/down counter with a run-time limit, wrap or saturate mode, cascade carry, match and wrap flags.
// Latency: dout, match and wrap_pulse update on each rising edge; carry_out is combinational.
// Backpressure: none; enable (or the upstream carry_out) is the only advance qualifier.
module mode_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             enable,
    input  logic             up_down,
    input  logic             saturate,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] compare_value,
    output logic [WIDTH-1:0] dout,
    output logic             carry_out,
    output logic             wrap_pulse,
    output logic             match
);

    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] next_val;
    logic             term;

    always_comb begin
        term     = up_down ? (dout >= limit) : (dout == '0);
        step_val = dout;
        if (up_down) begin
            if (dout < limit)
                step_val = dout + WIDTH'(1);
            else if (saturate)
                step_val = limit;   // also pulls an out-of-range count back after limit drops
            else
                step_val = '0;
        end else begin
            if (dout > limit)
                step_val = limit;
            else if (dout == '0)
                step_val = saturate ? '0 : limit;
            else
                step_val = dout - WIDTH'(1);
        end
    end

    always_comb begin
        next_val = dout;
        if (clear)
            next_val = '0;
        else if (load)
            next_val = (din > limit) ? limit : din;
        else if (enable)
            next_val = step_val;
    end

    // Zero-latency so a chained counter advances on the same edge as this one wraps.
    assign carry_out = enable & ~clear & ~load & term & ~saturate;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            wrap_pulse <= 1'b0;
            match      <= 1'b0;
        end else begin
            dout       <= next_val;
            wrap_pulse <= carry_out;
            match      <= (next_val == compare_value);
        end
    end

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
Parametrised up/down counter. It succeeds the fixed-modulus integer counter used for pixel, line and frame timing in the capture path. The terminal value is programmable at run time, and the block supports wrap or saturate mode, counting direction, and a cascade carry so instances can be chained (e.g. column -> row -> frame). It also provides a registered compare-match flag and a registered wrap pulse for downstream timing and interrupt logic.

Parameters:
WIDTH, 8, counter and data width in bits (>= 1)

Ports:
clock  in  1  rising-edge clock; the only clock domain
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear to 0; highest priority
load  in  1  synchronous load of din
din  in  WIDTH  load value
enable  in  1  count enable; tie to upstream carry_out when cascading
up_down  in  1  1 = count up, 0 = count down
saturate  in  1  1 = saturate at range end, 0 = wrap
limit  in  WIDTH  terminal value; legal range is 0..limit inclusive
compare_value  in  WIDTH  match threshold
dout  out  WIDTH  current count
carry_out  out  1  combinational; high when this cycle's enabled step wraps
wrap_pulse  out  1  registered one-cycle pulse after a wrap
match  out  1  registered; high while dout == compare_value as of the last update

Behaviour:
- Reset: asynchronous, active-high, as fixed above. reset=1 forces dout=0, wrap_pulse=0, match=0 immediately, with no clock edge needed. Release is synchronous to the next rising edge.
- Next-state priority, evaluated at each rising edge:
  - clear: next = 0.
  - else load: next = min(din, limit).
  - else enable: next = step(dout).
  - else: hold.
- Define term = (up_down ? dout >= limit : dout == 0).
- Up step:
  - dout < limit: dout + 1.
  - dout >= limit, wrap mode: 0 (wrap event).
  - dout >= limit, saturate mode: limit (no wrap event). This also snaps an out-of-range value down to limit after limit has been lowered.
- Down step:
  - dout > limit: limit. This is not a wrap event.
  - dout == 0, wrap mode: limit (wrap event).
  - dout == 0, saturate mode: hold at 0.
  - otherwise: dout - 1.
- Arithmetic is unsigned, modulo 2^WIDTH internally. No value outside 0..limit is ever produced by counting.
- carry_out = enable & ~clear & ~load & term & ~saturate. Zero latency, so a chained instance advances on the same edge. It is never asserted in saturate mode.
- wrap_pulse: registered copy of carry_out. It is high for exactly one cycle, coincident with the wrapped dout value. Consecutive wraps produce consecutive high cycles.
- match: registered, match <= (next == compare_value) at each edge, using the compare_value sampled at that edge.
  - After a compare_value change it updates at the next edge, even if dout holds.
  - Coming out of reset, match=0 until the first edge.
- limit == 0: dout stays 0. In wrap mode every enabled cycle is a wrap event, so carry_out=1 and wrap_pulse=1 continuously.
- limit == 2^WIDTH-1: full-range counter.
- Simultaneous clear/load/enable: priority as above. carry_out is suppressed whenever clear or load is high.
- Changing up_down, saturate or limit mid-count takes effect on the next edge. There is no internal state beyond dout, wrap_pulse and match.
- reset asserted mid-count: all outputs go to 0 asynchronously. The count resumes from 0 on the first enabled edge after release.

Test Plan:
- WIDTH=4, limit=9, up, wrap, enable=1 for 12 cycles -> dout 1..9,0,1,2; carry_out=1 while dout=9; wrap_pulse=1 only in the cycle dout=0.
- limit=9, down, saturate, load din=2 then enable 5 cycles -> dout 2,1,0,0,0,0; carry_out and wrap_pulse stay 0.
- load din=14 with limit=9 -> dout=9. Then limit lowered to 5 and one up-wrap step -> dout=0. A down step from 9 with limit=5 -> dout=5, wrap_pulse=0.
- Two instances cascaded (A.carry_out -> B.enable), limits 3 and 2, up, wrap, 12 enabled cycles -> B steps 0,1,2,0 at A's wraps; B.wrap_pulse after cycle 12.
- compare_value=6, up from 0 -> match=1 exactly when dout=6. compare_value changed to 7 with enable=0 -> match=0 next edge. clear together with load=1, din=6 -> dout=0.
- reset pulsed asynchronously between edges while dout=7 and wrap_pulse=1 -> dout, wrap_pulse and match drop to 0 before the next edge. After release, count restarts at 1 on the first enabled edge.
